// File: rtl/debug_data_sender_pkg.sv
// Shared definitions for the debug snapshot sender: state encodings,
// frame header byte and word-index offsets within a frame.
package debug_pkg;

    localparam int NB_STATE = 8;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE      = 8'b0000_0001,
        ST_SYNC      = 8'b0000_0010,
        ST_WAIT_SYNC = 8'b0000_0100,
        ST_FETCH     = 8'b0000_1000,
        ST_LOAD      = 8'b0001_0000,
        ST_SEND      = 8'b0010_0000,
        ST_WAIT_TX   = 8'b0100_0000,
        ST_DONE      = 8'b1000_0000
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Word order inside a frame: PC, cycle count, registers, then memory
    localparam int IDX_PC  = 0;
    localparam int IDX_CYC = 1;
    localparam int IDX_REG = 2;
    localparam int IDX_MEM = 34;

endpackage

// File: rtl/debug_data_sender_if.sv
// Bundle of the sender's handshake, read-port and tx_uart signals.
// master = the sender itself, slave = its surroundings.
interface debug_data_sender_if #(
    parameter int NB_DATA     = 32,
    parameter int NB_REG      = 5,
    parameter int NB_MEM_ADDR = 7
);
    logic                   start_i;
    logic [NB_DATA-1:0]     pc_i;
    logic [NB_DATA-1:0]     cycle_count_i;
    logic [NB_REG-1:0]      reg_addr_o;
    logic [NB_DATA-1:0]     reg_data_i;
    logic [NB_MEM_ADDR-1:0] mem_addr_o;
    logic                   mem_rd_en_o;
    logic [NB_DATA-1:0]     mem_data_i;
    logic [7:0]             tx_data_o;
    logic                   tx_start_o;
    logic                   tx_done_i;
    logic                   busy_o;
    logic                   done_o;

    modport master (
        input  start_i, pc_i, cycle_count_i, reg_data_i, mem_data_i, tx_done_i,
        output reg_addr_o, mem_addr_o, mem_rd_en_o, tx_data_o, tx_start_o,
               busy_o, done_o
    );

    modport slave (
        output start_i, pc_i, cycle_count_i, reg_data_i, mem_data_i, tx_done_i,
        input  reg_addr_o, mem_addr_o, mem_rd_en_o, tx_data_o, tx_start_o,
               busy_o, done_o
    );
endinterface

// File: rtl/debug_data_sender_shifter.sv
// Word-to-byte serialiser: loads a word, emits its bytes LSB first and
// flags the final byte of the word.
module word_byte_shifter #(
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               advance,
    input  logic [NB_DATA-1:0] load_word,
    output logic [7:0]         tx_byte,
    output logic               last_byte
);
    localparam int N_BYTES     = NB_DATA / 8;
    localparam int NB_BYTE_IDX = $clog2(N_BYTES);

    logic [NB_DATA-1:0]     shift_reg;
    logic [NB_DATA-1:0]     shift_next;
    logic [NB_BYTE_IDX-1:0] byte_idx_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_BYTES - 1; gi++) begin : g_byte
            assign shift_next[gi*8 +: 8] = shift_reg[(gi+1)*8 +: 8];
        end
    endgenerate
    assign shift_next[NB_DATA-1 -: 8] = 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg    <= '0;
            byte_idx_reg <= '0;
        end else if (load) begin
            shift_reg    <= load_word;
            byte_idx_reg <= '0;
        end else if (advance) begin
            shift_reg    <= shift_next;
            byte_idx_reg <= byte_idx_reg + 1'b1;
        end
    end

    assign tx_byte   = shift_reg[7:0];
    assign last_byte = (byte_idx_reg == NB_BYTE_IDX'(N_BYTES - 1));

endmodule

// File: rtl/debug_data_sender.sv
// Sends the debug snapshot frame (sync, PC, cycles, registers, memory)
// to tx_uart one byte at a time, each word LSB first.
module debug_data_sender
    import debug_pkg::*;
#(
    parameter int         NB_DATA     = 32,
    parameter int         NB_REG      = 5,
    parameter int         N_REGISTER  = 32,
    parameter int         NB_MEM_ADDR = 7,
    parameter int         N_MEM_WORDS = 128,
    parameter logic [7:0] SYNC_BYTE   = debug_pkg::SYNC_BYTE
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    debug_data_sender_if.master  bus
);
    localparam int MEM_BASE    = IDX_REG + N_REGISTER;
    localparam int N_WORDS     = MEM_BASE + N_MEM_WORDS;
    localparam int NB_WORD_IDX = $clog2(N_WORDS);

    typedef logic [NB_WORD_IDX-1:0] word_idx_t;

    state_t                 state_reg, state_next;
    word_idx_t              word_idx_reg, word_idx_next;
    logic [NB_DATA-1:0]     pc_snap_reg, cyc_snap_reg;
    logic [7:0]             tx_data_reg, tx_data_next;
    logic [NB_REG-1:0]      reg_addr_reg, reg_addr_next;
    logic [NB_MEM_ADDR-1:0] mem_addr_reg, mem_addr_next;
    logic [NB_DATA-1:0]     load_word;
    logic                   is_reg_word, is_mem_word, last_word;
    logic                   shift_load, shift_advance, last_byte;
    logic [7:0]             shift_byte;
    logic                   tx_start, busy, done, mem_rd_en;

    assign is_reg_word = (word_idx_reg >= word_idx_t'(IDX_REG)) &&
                         (word_idx_reg <  word_idx_t'(MEM_BASE));
    assign is_mem_word = (word_idx_reg >= word_idx_t'(MEM_BASE));
    assign last_word   = (word_idx_reg == word_idx_t'(N_WORDS - 1));

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg    <= ST_IDLE;
            word_idx_reg <= '0;
            pc_snap_reg  <= '0;
            cyc_snap_reg <= '0;
            tx_data_reg  <= '0;
            reg_addr_reg <= '0;
            mem_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            word_idx_reg <= word_idx_next;
            tx_data_reg  <= tx_data_next;
            reg_addr_reg <= reg_addr_next;
            mem_addr_reg <= mem_addr_next;
            // PC and cycle count are frozen for the whole frame
            if (state_reg == ST_IDLE && bus.start_i) begin
                pc_snap_reg  <= bus.pc_i;
                cyc_snap_reg <= bus.cycle_count_i;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        word_idx_next = word_idx_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_next    = ST_SYNC;
                    word_idx_next = '0;
                end
            end
            ST_SYNC:      state_next = ST_WAIT_SYNC;
            ST_WAIT_SYNC: begin
                if (bus.tx_done_i) begin
                    state_next    = ST_FETCH;
                    word_idx_next = '0;
                end
            end
            ST_FETCH:     state_next = ST_LOAD;
            ST_LOAD:      state_next = ST_SEND;
            ST_SEND:      state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (bus.tx_done_i) begin
                    if (!last_byte) begin
                        state_next = ST_SEND;
                    end else if (last_word) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next    = ST_FETCH;
                        word_idx_next = word_idx_reg + 1'b1;
                    end
                end
            end
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_start      = 1'b0;
        busy          = (state_reg != ST_IDLE);
        done          = 1'b0;
        mem_rd_en     = 1'b0;
        shift_load    = 1'b0;
        shift_advance = 1'b0;
        tx_data_next  = tx_data_reg;
        reg_addr_next = reg_addr_reg;
        mem_addr_next = mem_addr_reg;
        unique case (state_reg)
            ST_SYNC: begin
                tx_start     = 1'b1;
                tx_data_next = SYNC_BYTE;
            end
            ST_FETCH: begin
                // Addresses are presented in FETCH and stay registered through LOAD
                if (is_reg_word) begin
                    reg_addr_next = NB_REG'(32'(word_idx_reg) - IDX_REG);
                end
                if (is_mem_word) begin
                    mem_addr_next = NB_MEM_ADDR'(32'(word_idx_reg) - MEM_BASE);
                    mem_rd_en     = 1'b1;
                end
            end
            ST_LOAD:    shift_load = 1'b1;
            ST_SEND: begin
                tx_start     = 1'b1;
                tx_data_next = shift_byte;
            end
            ST_WAIT_TX: shift_advance = bus.tx_done_i && !last_byte;
            ST_DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        if (word_idx_reg == word_idx_t'(IDX_PC)) begin
            load_word = pc_snap_reg;
        end else if (word_idx_reg == word_idx_t'(IDX_CYC)) begin
            load_word = cyc_snap_reg;
        end else if (is_reg_word) begin
            load_word = bus.reg_data_i;
        end else begin
            load_word = bus.mem_data_i;
        end
    end

    word_byte_shifter #(
        .NB_DATA (NB_DATA)
    ) u_shifter (
        .clk       (clock_i),
        .rst_n     (reset_n_i),
        .load      (shift_load),
        .advance   (shift_advance),
        .load_word (load_word),
        .tx_byte   (shift_byte),
        .last_byte (last_byte)
    );

    assign bus.tx_data_o   = tx_data_next;
    assign bus.tx_start_o  = tx_start;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done;
    assign bus.mem_rd_en_o = mem_rd_en;
    assign bus.reg_addr_o  = reg_addr_next;
    assign bus.mem_addr_o  = mem_addr_next;

endmodule

// File: tb/tb_debug_data_sender.sv
// Directed bench for debug_data_sender with 4 memory words: table of
// frame scenarios plus reset-abort and back-to-back sequences.
module tb_debug_data_sender;

    localparam int N_MEM    = 4;
    localparam int FRAME_LEN = 1 + 4 * (34 + N_MEM);

    logic clk;
    logic rst_n;

    debug_data_sender_if #(.NB_DATA(32), .NB_REG(5), .NB_MEM_ADDR(7)) bus ();

    debug_data_sender #(
        .N_MEM_WORDS (N_MEM)
    ) u_dut (
        .clock_i   (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run    = 0;
    int tests_failed = 0;

    // Register file returns its own index; memory word k = DEAD_0000 + k, one-cycle read
    assign bus.reg_data_i = 32'(bus.reg_addr_o);
    always @(posedge clk) begin
        if (bus.mem_rd_en_o) bus.mem_data_i <= 32'hDEAD_0000 + 32'(bus.mem_addr_o);
    end

    logic uart_done, spurious_done, spur_en, prev_start;
    int   countdown;
    logic [7:0] captured[$];
    logic [7:0] exp_q[$];

    assign bus.tx_done_i = uart_done | spurious_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // tx_uart model: byte done 10 cycles after each start pulse
    initial begin
        uart_done = 0; spurious_done = 0; spur_en = 0; prev_start = 0; countdown = 0;
        forever begin
            @(negedge clk);
            spurious_done = 1'b0;
            if (!rst_n) begin
                uart_done = 0; countdown = 0; prev_start = 0;
            end else begin
                if (uart_done) begin
                    uart_done = 1'b0;
                    if (spur_en) spurious_done = 1'b1;
                end
                if (bus.tx_start_o) begin
                    captured.push_back(bus.tx_data_o);
                    check("tx_start one cycle wide", {31'b0, prev_start}, 32'd0);
                    countdown = 10;
                end else if (countdown > 0) begin
                    countdown--;
                    if (countdown == 0) uart_done = 1'b1;
                end
                prev_start = bus.tx_start_o;
            end
        end
    end

    task automatic build_expected(input logic [31:0] pc, input logic [31:0] cyc);
        logic [31:0] w;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 34 + N_MEM; k++) begin
            if (k == 0)       w = pc;
            else if (k == 1)  w = cyc;
            else if (k < 34)  w = 32'(k - 2);
            else              w = 32'hDEAD_0000 + 32'(k - 34);
            for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    function automatic logic [7:0] get_byte(input int i);
        if (i < captured.size()) return captured[i];
        return 8'hxx;
    endfunction

    // Called on a negedge; returns on the negedge where busy_o has dropped after done_o
    task automatic run_frame(input string name, input logic [31:0] pc, input logic [31:0] cyc,
                             input bit mess_pc, input bit spur, input bit mid_start);
        int  ndone;
        bit  finished;
        int  first_bad;
        captured.delete();
        build_expected(pc, cyc);
        spur_en = spur;
        bus.pc_i = pc;
        bus.cycle_count_i = cyc;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        check({name, " latency tx_start"}, {31'b0, bus.tx_start_o}, 32'd1);
        check({name, " latency tx_data"}, {24'b0, bus.tx_data_o}, 32'hA5);
        ndone = 0;
        finished = 0;
        for (int c = 0; c < 4000; c++) begin
            if (mess_pc && c == 0) bus.pc_i = 32'hFFFF_FFFF;
            bus.start_i = (mid_start && c == 200);
            @(negedge clk);
            if (bus.done_o) ndone++;
            if (ndone > 0 && !bus.busy_o) begin
                finished = 1;
                break;
            end
        end
        bus.start_i = 1'b0;
        spur_en = 1'b0;
        check({name, " frame completed in time"}, {31'b0, finished}, 32'd1);
        check({name, " done_o pulse count"}, 32'(ndone), 32'd1);
        check({name, " busy_o after done"}, {31'b0, bus.busy_o}, 32'd0);
        check({name, " byte count"}, 32'(captured.size()), 32'(FRAME_LEN));
        first_bad = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (get_byte(i) !== exp_q[i] && first_bad < 0) first_bad = i;
        end
        check({name, " first bad byte index"}, 32'(first_bad), 32'hFFFF_FFFF);
        $display("[TB] frame %s: %0d bytes, first byte %0h", name, captured.size(), get_byte(0));
    endtask

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] cyc;
        bit          mess_pc;
        bit          spur;
        bit          mid_start;
        int          exp_len;
        logic [7:0]  exp_b1;
        logic [7:0]  exp_b5;
        logic [7:0]  exp_b13;
        logic [7:0]  exp_b152;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"basic",    32'h0000_0040, 32'h0000_0123, 0, 0, 0, 153, 8'h40, 8'h23, 8'h01, 8'hDE};
        vecs[1] = '{"snapshot", 32'h0000_0040, 32'h0000_0123, 1, 0, 0, 153, 8'h40, 8'h23, 8'h01, 8'hDE};
        vecs[2] = '{"spurious", 32'h0000_0040, 32'h0000_0123, 0, 1, 1, 153, 8'h40, 8'h23, 8'h01, 8'hDE};
        vecs[3] = '{"pattern",  32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0, 153, 8'h78, 8'hF0, 8'h01, 8'hDE};

        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.pc_i = '0;
        bus.cycle_count_i = '0;
        repeat (2) @(negedge clk);
        check("reset busy_o",      {31'b0, bus.busy_o},      32'd0);
        check("reset tx_start_o",  {31'b0, bus.tx_start_o},  32'd0);
        check("reset done_o",      {31'b0, bus.done_o},      32'd0);
        check("reset mem_rd_en_o", {31'b0, bus.mem_rd_en_o}, 32'd0);
        check("reset tx_data_o",   {24'b0, bus.tx_data_o},   32'd0);
        check("reset reg_addr_o",  32'(bus.reg_addr_o),      32'd0);
        check("reset mem_addr_o",  32'(bus.mem_addr_o),      32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].name, vecs[v].pc, vecs[v].cyc,
                      vecs[v].mess_pc, vecs[v].spur, vecs[v].mid_start);
            check({vecs[v].name, " byte 1"},   {24'b0, get_byte(1)},   {24'b0, vecs[v].exp_b1});
            check({vecs[v].name, " byte 5"},   {24'b0, get_byte(5)},   {24'b0, vecs[v].exp_b5});
            check({vecs[v].name, " byte 13"},  {24'b0, get_byte(13)},  {24'b0, vecs[v].exp_b13});
            check({vecs[v].name, " byte 152"}, {24'b0, get_byte(152)}, {24'b0, vecs[v].exp_b152});
            repeat (30) @(negedge clk);
            check({vecs[v].name, " no second frame"}, 32'(captured.size()), 32'(vecs[v].exp_len));
            check({vecs[v].name, " idle busy_o"}, {31'b0, bus.busy_o}, 32'd0);
        end

        // Reset mid-frame while tx_start_o is high on the second byte of word 5
        begin
            bit reached;
            captured.delete();
            bus.pc_i = 32'h0000_0040;
            bus.cycle_count_i = 32'h0000_0123;
            bus.start_i = 1'b1;
            @(negedge clk);
            bus.start_i = 1'b0;
            reached = 0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                #1;
                if (captured.size() >= 23) begin
                    reached = 1;
                    break;
                end
            end
            check("reset abort reached word 5", {31'b0, reached}, 32'd1);
            check("reset abort tx_start before", {31'b0, bus.tx_start_o}, 32'd1);
            #1 rst_n = 1'b0;
            #1;
            check("reset abort busy_o",     {31'b0, bus.busy_o},     32'd0);
            check("reset abort tx_start_o", {31'b0, bus.tx_start_o}, 32'd0);
            check("reset abort done_o",     {31'b0, bus.done_o},     32'd0);
            $display("[TB] reset asserted after %0d bytes", captured.size());
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (2) @(negedge clk);
        end

        run_frame("after_reset", 32'h0000_0040, 32'h0000_0123, 0, 0, 0);
        run_frame("back_to_back", 32'h0000_0040, 32'h0000_0123, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
